// File: rtl/score_event_queue_pkg.sv
// Shared types, constants and BCD helpers for the score event queue.
// Amount layout: digit i occupies bits [4i:4i+3] of a [0:23] vector,
// digit 0 is least significant; inside a digit, bit 0 is the nibble MSB.
package score_pkg;

    localparam int DIGITS   = 6;
    localparam int AMOUNT_W = 24;

    typedef logic [0:3]                bcd_digit_t;
    typedef logic [0:DIGITS-1][0:3]    bcd_amount_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SETTLE = 2'd2
    } sq_state_t;

    // True when every nibble of the amount is a decimal digit (0..9).
    function automatic logic bcd_is_valid(input bcd_amount_t a);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[i] > 4'd9) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    // Magnitude compare a >= b, most significant digit (DIGITS-1) first.
    function automatic logic bcd_ge(input bcd_amount_t a, input bcd_amount_t b);
        logic decided;
        logic ge;
        decided = 1'b0;
        ge      = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (!decided && (a[i] != b[i])) begin
                decided = 1'b1;
                ge      = (a[i] > b[i]);
            end
        end
        return ge;
    endfunction

endpackage

// File: rtl/score_event_queue_if.sv
// Event input, accumulator-side and status signals of the score event queue.
// Handshake: an event transfers on a clock edge where evtValid && evtReady;
// the source holds evtSub/evtAmount stable with evtValid high until then.
interface score_event_if;
    import score_pkg::*;

    logic                    evtValid;
    logic                    evtSub;
    logic [0:AMOUNT_W-1]     evtAmount;
    logic                    evtReady;
    logic [0:AMOUNT_W-1]     balanceIn;
    logic                    enableAdd;
    logic                    enableSub;
    logic [0:AMOUNT_W-1]     amountOut;
    logic                    rejectPulse;
    logic                    busy;
    sq_state_t               stateDbg;

    modport master (
        output evtValid, evtSub, evtAmount, balanceIn,
        input  evtReady, enableAdd, enableSub, amountOut, rejectPulse, busy, stateDbg
    );

    modport slave (
        input  evtValid, evtSub, evtAmount, balanceIn,
        output evtReady, enableAdd, enableSub, amountOut, rejectPulse, busy, stateDbg
    );

endinterface

// File: rtl/score_event_queue_fifo.sv
// Show-ahead FIFO of {sub flag, BCD amount} events.
// Pointers carry one wrap bit so full and empty are distinguishable.
module score_event_fifo
    import score_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push,
    input  logic [AMOUNT_W:0]   pushData,
    input  logic                pop,
    output logic [AMOUNT_W:0]   headData,
    output logic                full,
    output logic                empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AMOUNT_W:0] mem [DEPTH];
    logic [AW:0]       wrPtr;
    logic [AW:0]       rdPtr;
    logic              doPush;
    logic              doPop;

    assign empty    = (wrPtr == rdPtr);
    assign full     = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign doPush   = push && !full;
    assign doPop    = pop && !empty;
    assign headData = mem[rdPtr[AW-1:0]];

    // Storage write; contents need no reset because pointers gate visibility.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr[AW-1:0]] <= pushData;
        end
    end

    // Pointer update; push and pop in the same cycle leave the count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/score_event_queue.sv
// Score event sequencer in front of the six-digit BCD accumulator.
// Queued events are issued as single-cycle enableAdd/enableSub pulses,
// two cycles apart, so each one is evaluated against a settled balance.
// Malformed BCD amounts are always dropped with rejectPulse.
// Build option: define SCORE_SUB_GUARD_EN to also drop subtracts whose
// amount exceeds balanceIn; without it the accumulator simply wraps.
module score_event_queue
    import score_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    score_event_if.slave  bus
);

    logic [AMOUNT_W:0] headData;
    logic              fifoFull;
    logic              fifoEmpty;
    logic              doPush;
    logic              doPop;
    logic              headSub;
    bcd_amount_t       headAmt;
    logic              headBadBcd;
    logic              headUnderflow;
    logic              dropHead;

    sq_state_t         state;
    logic              enableAddQ;
    logic              enableSubQ;
    logic              rejectQ;
    bcd_amount_t       amountQ;

    assign bus.evtReady = !fifoFull && !reset;
    assign doPush       = bus.evtValid && bus.evtReady;
    assign doPop        = ((state == IDLE) || (state == SETTLE)) && !fifoEmpty;

    score_event_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (doPush),
        .pushData ({bus.evtSub, bus.evtAmount}),
        .pop      (doPop),
        .headData (headData),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

    assign headSub = headData[AMOUNT_W];
    assign headAmt = headData[AMOUNT_W-1:0];

    // Drop decision for the head event, evaluated in the cycle it is popped.
    always_comb begin
        headBadBcd = !bcd_is_valid(headAmt);
`ifdef SCORE_SUB_GUARD_EN
        headUnderflow = headSub && !bcd_ge(bus.balanceIn, headAmt);
`else
        headUnderflow = 1'b0;
`endif
        dropHead = headBadBcd || headUnderflow;
    end

    // Sequencer FSM with registered enable, amount and reject outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            enableAddQ <= 1'b0;
            enableSubQ <= 1'b0;
            rejectQ    <= 1'b0;
            amountQ    <= '0;
        end else begin
            enableAddQ <= 1'b0;
            enableSubQ <= 1'b0;
            rejectQ    <= 1'b0;
            case (state)
                IDLE, SETTLE: begin
                    if (!fifoEmpty) begin
                        if (dropHead) begin
                            rejectQ <= 1'b1;
                            state   <= SETTLE;
                        end else begin
                            enableAddQ <= !headSub;
                            enableSubQ <= headSub;
                            amountQ    <= headAmt;
                            state      <= ISSUE;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                ISSUE: begin
                    // Accumulator captures on this edge; balance is valid in SETTLE.
                    state <= SETTLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.enableAdd   = enableAddQ;
    assign bus.enableSub   = enableSubQ;
    assign bus.amountOut   = amountQ;
    assign bus.rejectPulse = rejectQ;
    assign bus.busy        = !fifoEmpty || (state != IDLE);
    assign bus.stateDbg    = state;

endmodule
